// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo-MOD counter with parallel load and selectable
// terminal behaviour (wrap, saturate, one-shot).
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   enable, up_dn  step request and direction (1 = up)
//   load, load_val synchronous parallel load (clamped to MOD-1)
//   mode           00/11 wrap, 01 saturate, 10 one-shot
//   count          current count value
//   tc             one-cycle terminal-count pulse
//   done           sticky one-shot finished flag
//   wrap_cnt       saturating count of wrap events since reset or load
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MOD       = 256,
  parameter int unsigned RST_VAL   = 0,
  parameter int unsigned WRAP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 done,
  output logic [WRAP_BITS-1:0] wrap_cnt
);

  // The modulus may equal 2**WIDTH, so it is held with one extra bit.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RST_VAL);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 tc_q, tc_d;
  logic                 done_q, done_d;
  logic [WRAP_BITS-1:0] wrap_q, wrap_d;
  logic                 at_term;

  // Terminal detection; any out-of-range count also counts as terminal.
  always_comb begin
    if (up_dn) begin
      at_term = (count_q >= MAX_V);
    end else begin
      at_term = (count_q == '0) || (count_q > MAX_V);
    end
  end

  // Next-state logic: load has priority over a step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    wrap_d  = wrap_q;
    if (load) begin
      count_d = ({1'b0, load_val} >= MOD_W) ? MAX_V : load_val;
      done_d  = 1'b0;
      wrap_d  = '0;
    end else if (enable && !done_q) begin
      if (at_term) begin
        tc_d = 1'b1;
        unique case (mode)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: done_d  = 1'b1;
          default: begin
            count_d = up_dn ? '0 : MAX_V;
            if (!(&wrap_q)) begin
              wrap_d = wrap_q + WRAP_BITS'(1);
            end
          end
        endcase
      end else begin
        count_d = up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_V;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign done     = done_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [1:0] mode = 2'b00;

  logic [2:0] c8;   logic t8;  logic d8;  logic [3:0] w8;
  logic [7:0] c10;  logic t10; logic d10; logic [3:0] w10;
  logic [7:0] c100; logic t100; logic d100; logic [3:0] w100;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(3), .MOD(8), .RST_VAL(7), .WRAP_BITS(4)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val[2:0]), .mode(mode),
    .count(c8), .tc(t8), .done(d8), .wrap_cnt(w8));

  updown_mod_counter #(.WIDTH(8), .MOD(10), .RST_VAL(0), .WRAP_BITS(4)) dut10 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mode(mode),
    .count(c10), .tc(t10), .done(d10), .wrap_cnt(w10));

  updown_mod_counter #(.WIDTH(8), .MOD(100), .RST_VAL(0), .WRAP_BITS(4)) dut100 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mode(mode),
    .count(c100), .tc(t100), .done(d100), .wrap_cnt(w100));

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; step(); rst = 1'b0; enable = 1'b0;
    n_total++; if (c8 !== 3'd7) $display("FAIL reset_c8 got %0d exp 7", c8); else n_pass++;
    n_total++; if (t8 !== 1'b0) $display("FAIL reset_tc got %0d exp 0", t8); else n_pass++;
    n_total++; if (d8 !== 1'b0) $display("FAIL reset_done got %0d exp 0", d8); else n_pass++;
    n_total++; if (w8 !== 4'd0) $display("FAIL reset_wrap got %0d exp 0", w8); else n_pass++;
    n_total++; if (c10 !== 8'd0) $display("FAIL reset_c10 got %0d exp 0", c10); else n_pass++;
  endtask

  // Mod-8 down count from 7 with wrap.
  task automatic test_wrap_down();
    logic [2:0] exp_c [10] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
    logic       exp_t [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    rst = 1'b1; step(); rst = 1'b0;
    mode = 2'b00; up_dn = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (c8 !== exp_c[i]) $display("FAIL wrap_down_cnt[%0d] got %0d exp %0d", i, c8, exp_c[i]);
      else n_pass++;
      n_total++;
      if (t8 !== exp_t[i]) $display("FAIL wrap_down_tc[%0d] got %0d exp %0d", i, t8, exp_t[i]);
      else n_pass++;
    end
    enable = 1'b0;
    n_total++; if (w8 !== 4'd1) $display("FAIL wrap_down_wrap got %0d exp 1", w8); else n_pass++;
  endtask

  // Mod-10 up count with wrap, then wrap counter saturation.
  task automatic test_wrap_up();
    rst = 1'b1; step(); rst = 1'b0;
    mode = 2'b00; up_dn = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      n_total++;
      if (c10 !== 8'(i % 10)) $display("FAIL wrap_up_cnt[%0d] got %0d exp %0d", i, c10, i % 10);
      else n_pass++;
      n_total++;
      if (t10 !== ((i % 10) == 0)) $display("FAIL wrap_up_tc[%0d] got %0d exp %0d", i, t10, (i % 10) == 0);
      else n_pass++;
    end
    n_total++; if (w10 !== 4'd2) $display("FAIL wrap_up_wrap got %0d exp 2", w10); else n_pass++;
    for (int i = 0; i < 200; i++) step();
    enable = 1'b0;
    n_total++; if (w10 !== 4'd15) $display("FAIL wrap_sat got %0d exp 15", w10); else n_pass++;
    n_total++; if (c10 !== 8'd5) $display("FAIL wrap_up_end got %0d exp 5", c10); else n_pass++;
  endtask

  // Mode 11 behaves as wrap.
  task automatic test_mode3();
    load_val = 8'd7; load = 1'b1; step(); load = 1'b0;
    n_total++; if (w8 !== 4'd0) $display("FAIL mode3_load_wrap got %0d exp 0", w8); else n_pass++;
    mode = 2'b11; up_dn = 1'b1; enable = 1'b1; step(); enable = 1'b0;
    n_total++; if (c8 !== 3'd0) $display("FAIL mode3_cnt got %0d exp 0", c8); else n_pass++;
    n_total++; if (w8 !== 4'd1) $display("FAIL mode3_wrap got %0d exp 1", w8); else n_pass++;
    n_total++; if (t8 !== 1'b1) $display("FAIL mode3_tc got %0d exp 1", t8); else n_pass++;
  endtask

  task automatic test_saturate();
    logic exp_t [4] = '{0, 1, 1, 1};
    load_val = 8'd8; load = 1'b1; step(); load = 1'b0;
    mode = 2'b01; up_dn = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (c10 !== 8'd9) $display("FAIL sat_cnt[%0d] got %0d exp 9", i, c10); else n_pass++;
      n_total++;
      if (t10 !== exp_t[i]) $display("FAIL sat_tc[%0d] got %0d exp %0d", i, t10, exp_t[i]);
      else n_pass++;
    end
    up_dn = 1'b0; step(); enable = 1'b0;
    n_total++; if (c10 !== 8'd8) $display("FAIL sat_dir_cnt got %0d exp 8", c10); else n_pass++;
    n_total++; if (t10 !== 1'b0) $display("FAIL sat_dir_tc got %0d exp 0", t10); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c [6] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       exp_t [6] = '{0, 0, 0, 1, 0, 0};
    logic       exp_d [6] = '{0, 0, 0, 1, 1, 1};
    mode = 2'b10; up_dn = 1'b0;
    load_val = 8'd3; load = 1'b1; step(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_total++;
      if (c10 !== exp_c[i]) $display("FAIL os_cnt[%0d] got %0d exp %0d", i, c10, exp_c[i]); else n_pass++;
      n_total++;
      if (t10 !== exp_t[i]) $display("FAIL os_tc[%0d] got %0d exp %0d", i, t10, exp_t[i]); else n_pass++;
      n_total++;
      if (d10 !== exp_d[i]) $display("FAIL os_done[%0d] got %0d exp %0d", i, d10, exp_d[i]); else n_pass++;
    end
    enable = 1'b0;
    load_val = 8'd5; load = 1'b1; step(); load = 1'b0;
    n_total++; if (d10 !== 1'b0) $display("FAIL os_reload_done got %0d exp 0", d10); else n_pass++;
    n_total++; if (c10 !== 8'd5) $display("FAIL os_reload_cnt got %0d exp 5", c10); else n_pass++;
    enable = 1'b1; step(); enable = 1'b0;
    n_total++; if (c10 !== 8'd4) $display("FAIL os_resume got %0d exp 4", c10); else n_pass++;
  endtask

  task automatic test_load_clamp();
    mode = 2'b00; up_dn = 1'b1;
    load_val = 8'd200; load = 1'b1; enable = 1'b1; step();
    n_total++; if (c100 !== 8'd99) $display("FAIL clamp100 got %0d exp 99", c100); else n_pass++;
    n_total++; if (t100 !== 1'b0) $display("FAIL clamp_tc got %0d exp 0", t100); else n_pass++;
    n_total++; if (c10 !== 8'd9) $display("FAIL clamp10 got %0d exp 9", c10); else n_pass++;
    load_val = 8'd50; step();
    n_total++; if (c100 !== 8'd50) $display("FAIL load_nostep got %0d exp 50", c100); else n_pass++;
    load = 1'b0; step();
    n_total++; if (c100 !== 8'd51) $display("FAIL after_load_step got %0d exp 51", c100); else n_pass++;
    rst = 1'b1; load = 1'b1; step(); rst = 1'b0; load = 1'b0; enable = 1'b0;
    n_total++; if (c100 !== 8'd0) $display("FAIL rst_load100 got %0d exp 0", c100); else n_pass++;
    n_total++; if (c8 !== 3'd7) $display("FAIL rst_load8 got %0d exp 7", c8); else n_pass++;
  endtask

  task automatic test_rst_mid();
    mode = 2'b00; up_dn = 1'b1;
    load_val = 8'd0; load = 1'b1; step(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) step();
    mode = 2'b10;
    for (int i = 0; i < 10; i++) step();
    n_total++; if (d10 !== 1'b1) $display("FAIL mid_done got %0d exp 1", d10); else n_pass++;
    n_total++; if (w10 !== 4'd2) $display("FAIL mid_wrap got %0d exp 2", w10); else n_pass++;
    n_total++; if (c10 !== 8'd9) $display("FAIL mid_cnt got %0d exp 9", c10); else n_pass++;
    rst = 1'b1; step(); rst = 1'b0; enable = 1'b0;
    n_total++; if (c10 !== 8'd0) $display("FAIL mid_rst_cnt got %0d exp 0", c10); else n_pass++;
    n_total++; if (t10 !== 1'b0) $display("FAIL mid_rst_tc got %0d exp 0", t10); else n_pass++;
    n_total++; if (d10 !== 1'b0) $display("FAIL mid_rst_done got %0d exp 0", d10); else n_pass++;
    n_total++; if (w10 !== 4'd0) $display("FAIL mid_rst_wrap got %0d exp 0", w10); else n_pass++;
    step();
    n_total++; if (c10 !== 8'd0) $display("FAIL idle_hold got %0d exp 0", c10); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap_down();
    test_wrap_up();
    test_mode3();
    test_saturate();
    test_oneshot();
    test_load_clamp();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
